// File: rtl/alarm_pkg.sv
// Shared constants for the three-sensor intrusion alarm.
package alarm_pkg;

  localparam int unsigned NUM_SENSORS = 3;
  localparam int unsigned CNT_W       = 8;

  localparam int unsigned MOTION = 0;
  localparam int unsigned DOOR   = 1;
  localparam int unsigned WINDOW = 2;

endpackage : alarm_pkg

// File: rtl/alarm_sensor_filter.sv
// One sensor channel: multi-flop synchronizer followed by a saturating debounce counter.
module alarm_sensor_filter
  import alarm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_in,
  output logic qualified
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sensor_sync;

  assign sensor_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sensor_in};
  end

  always_comb begin
    cnt_d = '0;
    if (sensor_sync) begin
      cnt_d = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Gating with the synchronized level makes the count read as zero in the
  // very cycle the sensor drops, so release is not delayed by the counter flop.
  assign qualified = sensor_sync && (cnt_q == DEB_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : alarm_sensor_filter

// File: rtl/tt_um_umar316798.sv
// Intrusion alarm top: reset synchronizer, three filtered sensors, OR trigger, alarm flop.
module tt_um_umar316798
  import alarm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LATCH_ALARM     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SENSORS-1:0] ui_in,
  output logic                   uo_out
);

  logic [1:0]             rst_sync_q, rst_sync_d;
  logic                   rst_int_n;
  logic [NUM_SENSORS-1:0] qual;
  logic                   trigger;
  logic                   alarm_q, alarm_d;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  alarm_sensor_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_motion (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .sensor_in(ui_in[MOTION]),
    .qualified(qual[MOTION])
  );

  alarm_sensor_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_door (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .sensor_in(ui_in[DOOR]),
    .qualified(qual[DOOR])
  );

  alarm_sensor_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .sensor_in(ui_in[WINDOW]),
    .qualified(qual[WINDOW])
  );

  assign trigger = |qual;

  always_comb begin
    alarm_d = trigger;
    if (LATCH_ALARM != 0) alarm_d = trigger || alarm_q;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) alarm_q <= 1'b0;
    else            alarm_q <= alarm_d;
  end

  assign uo_out = alarm_q;

endmodule : tt_um_umar316798

// File: tb/tb_tt_um_umar316798.sv
// Directed bench: one latching and one following alarm instance driven in parallel.
module tb_tt_um_umar316798;

  logic       clk;
  logic       rst_n;
  logic [2:0] ui_in;
  logic       uo_latch;
  logic       uo_follow;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  tt_um_umar316798 #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .LATCH_ALARM    (1)
  ) u_dut_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .ui_in (ui_in),
    .uo_out(uo_latch)
  );

  tt_um_umar316798 #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .LATCH_ALARM    (0)
  ) u_dut_follow (
    .clk   (clk),
    .rst_n (rst_n),
    .ui_in (ui_in),
    .uo_out(uo_follow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ui_in = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Apply a sensor code after a fresh reset; alarm must be low after edge 6, high after edge 7.
  task automatic run_code(input logic [2:0] code, input string tag);
    do_reset();
    @(negedge clk);
    ui_in = code;
    repeat (6) @(posedge clk);
    #1;
    check_eq({tag, "_e6_latch"},  {31'd0, uo_latch},  32'd0);
    check_eq({tag, "_e6_follow"}, {31'd0, uo_follow}, 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_e7_latch"},  {31'd0, uo_latch},  32'd1);
    check_eq({tag, "_e7_follow"}, {31'd0, uo_follow}, 32'd1);
  endtask

  // High pulse lasting n sampled edges; reports whether the latching alarm ever rose.
  task automatic run_pulse(input int unsigned n, output logic seen);
    do_reset();
    seen = 1'b0;
    @(negedge clk);
    ui_in = 3'b001;
    repeat (n) @(negedge clk);
    ui_in = 3'b000;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen = seen | uo_latch;
    end
  endtask

  logic seen;
  logic all_high;

  initial begin
    rst_n = 1'b0;
    ui_in = 3'b000;
    #12;
    check_eq("reset_latch",  {31'd0, uo_latch},  32'd0);
    check_eq("reset_follow", {31'd0, uo_follow}, 32'd0);

    // Idle for 50 cycles
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      seen = seen | uo_latch | uo_follow;
    end
    check_eq("idle_50", {31'd0, seen}, 32'd0);

    // Single and combined sensors share the same latency
    run_code(3'b001, "motion");
    run_code(3'b010, "door");
    run_code(3'b100, "window");
    run_code(3'b011, "c011");
    run_code(3'b101, "c101");
    run_code(3'b110, "c110");
    run_code(3'b111, "c111");

    // Short pulse rejected, longer pulse accepted
    run_pulse(3, seen);
    check_eq("pulse3", {31'd0, seen}, 32'd0);
    run_pulse(5, seen);
    check_eq("pulse5", {31'd0, seen}, 32'd1);

    // Latch holds, follower drops 3 edges after sensors clear
    do_reset();
    @(negedge clk);
    ui_in = 3'b010;
    repeat (10) @(negedge clk);
    check_eq("raised_latch",  {31'd0, uo_latch},  32'd1);
    check_eq("raised_follow", {31'd0, uo_follow}, 32'd1);
    ui_in = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("drop_e2_follow", {31'd0, uo_follow}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("drop_e3_follow", {31'd0, uo_follow}, 32'd0);
    repeat (10) @(negedge clk);
    check_eq("hold_latch", {31'd0, uo_latch}, 32'd1);

    // Asynchronous reset clears the latched alarm before any clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_latch", {31'd0, uo_latch}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counters must saturate, not wrap, over a long high period
    do_reset();
    @(negedge clk);
    ui_in = 3'b001;
    repeat (10) @(negedge clk);
    all_high = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      all_high = all_high & uo_follow;
    end
    check_eq("saturate_follow", {31'd0, all_high}, 32'd1);

    // Reset mid-debounce; full latency again after release (2 sync-reset edges + 7)
    do_reset();
    @(negedge clk);
    ui_in = 3'b111;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_latch", {31'd0, uo_latch}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("rerun_e8_latch", {31'd0, uo_latch}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rerun_e9_latch", {31'd0, uo_latch}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tt_um_umar316798
